// File: rtl/ones_count_scheduler.sv
// Round-robin scheduler sharing one ones-count engine among N_REQ requesters.
// One-hot FSM: IDLE arbitrates, ISSUE starts the engine, WAIT collects the count (or times out), DONE pulses done.
//
//   state | meaning
//   IDLE  | no transfer; arbitrate among req from ptr
//   ISSUE | cnt_start held until the engine accepts it
//   WAIT  | wait for engine count or timeout
//   DONE  | one-cycle done pulse, advance ptr
module ones_count_scheduler #(
  parameter int N_REQ   = 4,
  parameter int R1_size = 8,
  parameter int R2_size = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*R1_size-1:0]   req_data,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic                       err,
  output logic [R2_size-1:0]         result,
  output logic                       busy,
  output logic                       cnt_start,
  output logic [R1_size-1:0]         cnt_data,
  input  logic                       cnt_ready,
  input  logic [R2_size-1:0]         cnt_count
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  state_t               state, state_nx;
  logic [IDX_W-1:0]     idx, ptr, win_idx;
  logic                 win_found;
  logic [R1_size-1:0]   op, win_data;
  logic [R2_size-1:0]   result_q;
  logic                 err_q;
  logic [TMO_W-1:0]     tmo;
  logic                 latch, capture, timeout;
  logic [2*N_REQ-1:0]   req_dbl;
  logic [IDX_W:0]       sum;
  logic [N_REQ-1:0]     idx_oh;

  // Rotate req so bit 0 is the ptr requester; the lowest set bit wins.
  always_comb begin
    req_dbl   = {req, req} >> ptr;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req_dbl[i]) begin
        win_found = 1'b1;
        sum = {1'b0, ptr} + (IDX_W+1)'(i);
        if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
        win_idx = sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) win_data = req_data[i*R1_size +: R1_size];
    end
  end

  // The engine holds cnt_ready from the previous count during the first WAIT cycle, so tmo==0 masks it.
  always_comb begin
    state_nx = state;
    latch    = 1'b0;
    capture  = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          latch    = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_ready) state_nx = WAIT;
      end
      WAIT: begin
        if (tmo != '0 && cnt_ready) begin
          capture  = 1'b1;
          state_nx = DONE;
        end else if (tmo == TMO_W'(TIMEOUT)) begin
          timeout  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      ptr      <= '0;
      op       <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      tmo      <= '0;
    end else begin
      state <= state_nx;
      err_q <= timeout;
      if (latch) begin
        idx <= win_idx;
        op  <= win_data;
      end
      if (state == WAIT && state_nx == WAIT) tmo <= tmo + 1'b1;
      else                                   tmo <= '0;
      if (capture)      result_q <= cnt_count;
      else if (timeout) result_q <= '0;
      if (state == DONE) ptr <= (idx == IDX_W'(N_REQ-1)) ? '0 : idx + 1'b1;
    end
  end

  assign idx_oh    = N_REQ'(1) << idx;
  assign busy      = (state != IDLE);
  assign cnt_start = (state == ISSUE);
  assign cnt_data  = op;
  assign gnt       = busy ? idx_oh : '0;
  assign done      = (state == DONE) ? idx_oh : '0;
  assign err       = err_q;
  assign result    = result_q;

endmodule

// File: doc/ones_count_scheduler.md
ONES_COUNT_SCHEDULER -- requirements
Module: ones_count_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4: number of requesters.
REQ-002 The block SHALL have parameter R1_size, default 8: operand width.
REQ-003 The block SHALL have parameter R2_size, default 4: count width.
REQ-004 The block SHALL have parameter TIMEOUT, default 64: maximum cycles to wait for engine completion.
REQ-005 The block SHALL have port clock, input, 1: rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port req, input, N_REQ: per-requester request level.
REQ-008 The block SHALL have port req_data, input, N_REQ*R1_size: operand of requester i at bits [i*R1_size +: R1_size].
REQ-009 The block SHALL have port gnt, output, N_REQ: one-hot grant.
REQ-010 The block SHALL have port done, output, N_REQ: one-cycle completion pulse per requester.
REQ-011 The block SHALL have port err, output, 1: timeout flag, valid with done.
REQ-012 The block SHALL have port result, output, R2_size: ones count, valid while any done bit is 1.
REQ-013 The block SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 The block SHALL have port cnt_start, output, 1: start strobe to the shared ones-count engine.
REQ-015 The block SHALL have port cnt_data, output, R1_size: operand to the engine.
REQ-016 The block SHALL have port cnt_ready, input, 1: engine idle/result-valid.
REQ-017 The block SHALL have port cnt_count, input, R2_size: engine count.

Function
REQ-018 The engine contract SHALL be: cnt_start is sampled on a rising edge while cnt_ready=1; cnt_ready=0 from the next cycle until the count is final; cnt_count is valid when cnt_ready returns to 1.
REQ-019 The FSM SHALL have four states, IDLE, ISSUE, WAIT and DONE, using one-hot encoding.
REQ-020 In IDLE with any req bit set, the block SHALL select the winner by round-robin starting at pointer ptr, latch its index and req_data into internal registers, and go to ISSUE.
REQ-021 In IDLE with req=0, the block SHALL stay in IDLE.
REQ-022 In ISSUE the block SHALL drive cnt_start=1 and cnt_data=latched operand, with gnt[idx]=1.
REQ-023 In ISSUE with cnt_ready=1, the block SHALL go to WAIT; otherwise it SHALL stay in ISSUE with cnt_start held.
REQ-024 cnt_start SHALL be high only in ISSUE.
REQ-025 cnt_data SHALL hold the latched operand from ISSUE through DONE.
REQ-026 In WAIT the block SHALL ignore cnt_ready during the first WAIT cycle.
REQ-027 In WAIT, from the second WAIT cycle on, cnt_ready=1 SHALL cause the block to capture cnt_count into result and go to DONE.
REQ-028 The block SHALL run a timeout counter of width clog2(TIMEOUT+1) in WAIT; when the counter reaches TIMEOUT, the block SHALL set result=0 and err=1 and go to DONE.
REQ-029 In DONE the block SHALL pulse done[idx]=1 for exactly one cycle, set ptr=(idx+1) mod N_REQ, and go to IDLE.
REQ-030 gnt[idx] SHALL be held from ISSUE through DONE inclusive, and gnt SHALL be 0 in IDLE.
REQ-031 err SHALL be 1 only in DONE after a timeout.
REQ-032 result SHALL hold its value until the next capture.
REQ-033 A requester SHALL hold req until its done pulse; deasserting req mid-operation SHALL NOT abort the operation (the done pulse is still issued).
REQ-034 Requests arriving while busy=1 SHALL wait; arbitration SHALL occur only in IDLE.
REQ-035 Simultaneous requests SHALL be served in round-robin order from ptr; no requester SHALL wait more than N_REQ-1 other grants.
REQ-036 Minimum latency from req rising (sampled in IDLE) to done SHALL be 4 cycles plus the engine busy time.
REQ-037 An operand of 0 SHALL be forwarded normally, with result equal to the engine count (0).

Reset
REQ-038 While reset=0, the block SHALL be asynchronously forced to state=IDLE, ptr=0, gnt=0, done=0, err=0, result=0, cnt_start=0, cnt_data=0, busy=0, and timeout counter=0.
REQ-039 Reset mid-operation SHALL abandon the transfer with no done pulse.
REQ-040 After reset release, the first arbitration SHALL occur on the first rising edge with reset=1.

Verification
REQ-041 The bench SHALL cover: req=0001, req_data[7:0]=8'h4C, engine model -> one cnt_start pulse, gnt=0001, done=0001 one cycle, result=3, err=0.
REQ-042 The bench SHALL cover: req=1111 held, operands 8'hFF/8'h01/8'h00/8'hAA -> grants in order 0,1,2,3,0, results 8, 1, 0, 4.
REQ-043 The bench SHALL cover: requester 0 re-requests immediately after its done while req[2]=1 -> requester 2 is granted before requester 0.
REQ-044 The bench SHALL cover: the engine model never raises cnt_ready after start -> after TIMEOUT cycles in WAIT, done[idx]=1, err=1, result=0, then IDLE.
REQ-045 The bench SHALL cover: cnt_ready held 0 during ISSUE for 5 cycles -> cnt_start stays 1 for all 5 cycles, with a single start accepted.
REQ-046 The bench SHALL cover: reset=0 asserted in WAIT -> all outputs 0 immediately, no done pulse, and the next grant goes to requester 0.
